// File: rtl/mmio_mailbox.sv
// mmio_mailbox: memory-mapped TX/RX word FIFOs with valid/ready links to external agents.
// Optional interrupt output and CTRL enable bits are built when MAILBOX_IRQ_EN is defined.
`default_nettype none

module mmio_mailbox #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_1000,
  parameter int          DEPTH     = 8,
  parameter int          DATA_W    = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              WE,
  input  logic [31:0]       A,
  input  logic [31:0]       WD,
  output logic [31:0]       RD,
  output logic              sel,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic [DATA_W-1:0] tx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  input  logic [DATA_W-1:0] rx_data
`ifdef MAILBOX_IRQ_EN
  ,
  output logic              irq
`endif
);

  localparam int            AW       = $clog2(DEPTH);
  localparam int            CW       = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [DATA_W-1:0] tx_mem [DEPTH];
  logic [DATA_W-1:0] rx_mem [DEPTH];
  logic [AW-1:0]     tx_wp, tx_rp, rx_wp, rx_rp;
  logic [CW-1:0]     tx_cnt, rx_cnt, tx_cnt_nx, rx_cnt_nx;
  logic              tx_ovf, rx_unf, tx_en, ie_rx, ie_tx;

  logic [1:0] off;
  logic       wr, wr_tx, wr_rx, wr_stat, wr_ctrl, flush;
  logic       tx_full, tx_empty, rx_full, rx_empty;
  logic       tx_push, tx_pop, rx_push, rx_pop;
  logic       unused_addr;

  assign sel      = (A[31:4] == BASE_ADDR[31:4]);
  assign off      = A[3:2];
  assign wr       = sel && WE;
  assign wr_tx    = wr && (off == 2'd0);
  assign wr_rx    = wr && (off == 2'd1);
  assign wr_stat  = wr && (off == 2'd2);
  assign wr_ctrl  = wr && (off == 2'd3);
  assign flush    = wr_ctrl && WD[1];
  assign unused_addr = ^A[1:0];

  assign tx_full  = (tx_cnt == FULL_CNT);
  assign tx_empty = (tx_cnt == '0);
  assign rx_full  = (rx_cnt == FULL_CNT);
  assign rx_empty = (rx_cnt == '0);

  assign tx_valid = !tx_empty && tx_en;
  assign tx_data  = tx_mem[tx_rp];
  assign rx_ready = !rx_full;

  assign tx_push  = wr_tx && !tx_full;
  assign tx_pop   = tx_valid && tx_ready;
  assign rx_push  = rx_valid && !rx_full;
  assign rx_pop   = wr_rx && !rx_empty;

  always_comb begin
    tx_cnt_nx = tx_cnt;
    rx_cnt_nx = rx_cnt;
    if (flush) begin
      tx_cnt_nx = '0;
      rx_cnt_nx = '0;
    end else begin
      if (tx_push && !tx_pop)      tx_cnt_nx = tx_cnt + CW'(1);
      else if (tx_pop && !tx_push) tx_cnt_nx = tx_cnt - CW'(1);
      if (rx_push && !rx_pop)      rx_cnt_nx = rx_cnt + CW'(1);
      else if (rx_pop && !rx_push) rx_cnt_nx = rx_cnt - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tx_wp  <= '0;
      tx_rp  <= '0;
      rx_wp  <= '0;
      rx_rp  <= '0;
      tx_cnt <= '0;
      rx_cnt <= '0;
      tx_ovf <= 1'b0;
      rx_unf <= 1'b0;
      tx_en  <= 1'b1;
    end else begin
      tx_cnt <= tx_cnt_nx;
      rx_cnt <= rx_cnt_nx;
      if (flush) begin
        tx_wp <= '0;
        tx_rp <= '0;
        rx_wp <= '0;
        rx_rp <= '0;
      end else begin
        if (tx_push) tx_wp <= tx_wp + AW'(1);
        if (tx_pop)  tx_rp <= tx_rp + AW'(1);
        if (rx_push) rx_wp <= rx_wp + AW'(1);
        if (rx_pop)  rx_rp <= rx_rp + AW'(1);
      end
      // A new set event outranks a same-edge write-1-to-clear.
      if (wr_tx && tx_full)       tx_ovf <= 1'b1;
      else if (wr_stat && WD[4])  tx_ovf <= 1'b0;
      if (wr_rx && rx_empty)      rx_unf <= 1'b1;
      else if (wr_stat && WD[5])  rx_unf <= 1'b0;
      if (wr_ctrl)                tx_en  <= WD[0];
    end
  end

  always_ff @(posedge clk) begin
    if (tx_push && !flush) tx_mem[tx_wp] <= DATA_W'(WD);
    if (rx_push && !flush) rx_mem[rx_wp] <= rx_data;
  end

`ifdef MAILBOX_IRQ_EN
  logic ie_rx_nx, ie_tx_nx;
  assign ie_rx_nx = wr_ctrl ? WD[2] : ie_rx;
  assign ie_tx_nx = wr_ctrl ? WD[3] : ie_tx;

  // irq reflects the state that will exist after this edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ie_rx <= 1'b0;
      ie_tx <= 1'b0;
      irq   <= 1'b0;
    end else begin
      ie_rx <= ie_rx_nx;
      ie_tx <= ie_tx_nx;
      irq   <= (ie_rx_nx && (rx_cnt_nx != '0)) || (ie_tx_nx && (tx_cnt_nx == '0));
    end
  end
`else
  assign ie_rx = 1'b0;
  assign ie_tx = 1'b0;
`endif

  always_comb begin
    RD = '0;
    if (sel) begin
      case (off)
        2'd1: if (!rx_empty) RD = 32'(rx_mem[rx_rp]);
        2'd2: RD = {8'd0, 8'(rx_cnt), 8'(tx_cnt), 2'd0, rx_unf, tx_ovf,
                    rx_empty, rx_full, tx_empty, tx_full};
        2'd3: RD = {28'd0, ie_tx, ie_rx, 1'b0, tx_en};
        default: RD = '0;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mmio_mailbox.sv
// tb_mmio_mailbox: table-driven directed bench for mmio_mailbox plus hand-written reset/window sequences.
`default_nettype none

module tb_mmio_mailbox;

  logic        clk = 1'b0;
  logic        reset;
  logic        WE;
  logic [31:0] A, WD, RD;
  logic        sel, tx_valid, tx_ready, rx_valid, rx_ready;
  logic [31:0] tx_data, rx_data;
`ifdef MAILBOX_IRQ_EN
  logic        irq;
`endif

  int total = 0;
  int bad   = 0;

  mmio_mailbox dut (
    .clk(clk), .reset(reset), .WE(WE), .A(A), .WD(WD), .RD(RD), .sel(sel),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_data(tx_data),
    .rx_valid(rx_valid), .rx_ready(rx_ready), .rx_data(rx_data)
`ifdef MAILBOX_IRQ_EN
    , .irq(irq)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [1:0]  off;
    logic [31:0] wd;
    logic        txr;
    logic        rxv;
    logic [31:0] rxd;
    logic        chk_rd;
    logic [31:0] rd;
    logic        txv;
    logic        rxr;
    logic        chk_txd;
    logic [31:0] txd;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic we, input logic [1:0] off, input logic [31:0] wd,
                     input logic txr, input logic rxv, input logic [31:0] rxd,
                     input logic chk_rd, input logic [31:0] rd, input logic txv,
                     input logic rxr, input logic chk_txd, input logic [31:0] txd);
    vec_t v;
    v.we = we; v.off = off; v.wd = wd; v.txr = txr; v.rxv = rxv; v.rxd = rxd;
    v.chk_rd = chk_rd; v.rd = rd; v.txv = txv; v.rxr = rxr;
    v.chk_txd = chk_txd; v.txd = txd;
    vq.push_back(v);
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", nm, act, exp);
    end
  endtask

  // Drive one vector, compare pre-edge outputs, then take the clock edge.
  task automatic apply(input vec_t v, input int idx);
    WE       = v.we;
    A        = 32'h0000_1000 | {28'd0, v.off, 2'b00};
    WD       = v.wd;
    tx_ready = v.txr;
    rx_valid = v.rxv;
    rx_data  = v.rxd;
    #2;
    check($sformatf("v%0d_sel", idx), {31'd0, sel}, 32'd1);
    if (v.chk_rd) check($sformatf("v%0d_rd", idx), RD, v.rd);
    check($sformatf("v%0d_tx_valid", idx), {31'd0, tx_valid}, {31'd0, v.txv});
    check($sformatf("v%0d_rx_ready", idx), {31'd0, rx_ready}, {31'd0, v.rxr});
    if (v.chk_txd) check($sformatf("v%0d_tx_data", idx), tx_data, v.txd);
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0; WE = 1'b0; A = '0; WD = '0;
    tx_ready = 1'b0; rx_valid = 1'b0; rx_data = '0;

    // Reset state and basic TX ordering.
    add(0,2,0,0,0,0, 1,32'h0000_000A, 0,1, 0,0);
    add(1,0,32'h11,0,0,0, 1,0, 0,1, 0,0);
    add(1,0,32'h22,0,0,0, 1,0, 1,1, 1,32'h11);
    add(1,0,32'h33,0,0,0, 1,0, 1,1, 1,32'h11);
    add(0,2,0,0,0,0, 1,32'h308, 1,1, 1,32'h11);
    add(0,2,0,1,0,0, 1,32'h308, 1,1, 1,32'h11);
    add(0,2,0,1,0,0, 1,32'h208, 1,1, 1,32'h22);
    add(0,2,0,1,0,0, 1,32'h108, 1,1, 1,32'h33);
    add(0,2,0,0,0,0, 1,32'h0A, 0,1, 0,0);

    // Overflow: DEPTH+1 writes, then W1C on tx_ovf, then drain.
    for (int i = 0; i < 9; i++)
      add(1,0,32'h100+i,0,0,0, 1,0, (i>0),1, (i>0),32'h100);
    add(0,2,0,0,0,0, 1,32'h819, 1,1, 1,32'h100);
    add(1,2,32'h10,0,0,0, 1,32'h819, 1,1, 1,32'h100);
    add(0,2,0,0,0,0, 1,32'h809, 1,1, 1,32'h100);
    for (int i = 0; i < 8; i++)
      add(0,2,0,1,0,0, 1,((32'(8-i))<<8)|32'h8|((i==0)?32'h1:32'h0), 1,1, 1,32'h100+i);
    add(0,2,0,0,0,0, 1,32'h0A, 0,1, 0,0);

    // RX push, pop, underflow, W1C.
    add(0,1,0,0,1,32'hA5A5_0001, 1,0, 0,1, 0,0);
    add(0,1,0,0,1,32'hA5A5_0002, 1,32'hA5A5_0001, 0,1, 0,0);
    add(0,2,0,0,0,0, 1,32'h0002_0002, 0,1, 0,0);
    add(1,1,0,0,0,0, 1,32'hA5A5_0001, 0,1, 0,0);
    add(0,1,0,0,0,0, 1,32'hA5A5_0002, 0,1, 0,0);
    add(1,1,0,0,0,0, 1,32'hA5A5_0002, 0,1, 0,0);
    add(1,1,0,0,0,0, 1,0, 0,1, 0,0);
    add(0,2,0,0,0,0, 1,32'h2A, 0,1, 0,0);
    add(1,2,32'h20,0,0,0, 1,32'h2A, 0,1, 0,0);
    add(0,2,0,0,0,0, 1,32'h0A, 0,1, 0,0);

    // DEPTH-1 entries, push+pop same edge, drain across the pointer wrap.
    for (int i = 0; i < 7; i++)
      add(1,0,32'h200+i,0,0,0, 1,0, (i>0),1, (i>0),32'h200);
    add(1,0,32'h207,1,0,0, 1,0, 1,1, 1,32'h200);
    for (int i = 0; i < 7; i++)
      add(0,2,0,1,0,0, 1,((32'(7-i))<<8)|32'h8, 1,1, 1,32'h201+i);
    add(0,2,0,0,0,0, 1,32'h0A, 0,1, 0,0);

    // tx_en gating.
    add(1,3,0,0,0,0, 1,32'h1, 0,1, 0,0);
    add(1,0,32'h300,0,0,0, 1,0, 0,1, 0,0);
    add(0,2,0,1,0,0, 1,32'h108, 0,1, 0,0);
    add(1,3,1,0,0,0, 1,32'h0, 0,1, 0,0);
    add(0,3,0,1,0,0, 1,32'h1, 1,1, 1,32'h300);
    add(0,2,0,0,0,0, 1,32'h0A, 0,1, 0,0);

    // Fill both FIFOs, flush with a same-edge RX offer.
    for (int i = 0; i < 8; i++)
      add(1,0,32'h400+i,0,1,32'hB000+i, 1,0, (i>0),1, (i>0),32'h400);
    add(0,2,0,0,0,0, 1,32'h0008_0805, 1,0, 1,32'h400);
    add(1,3,32'h3,0,1,32'hDEAD, 1,32'h1, 1,0, 1,32'h400);
    add(0,2,0,0,0,0, 1,32'h0A, 0,1, 0,0);
    add(0,3,0,0,0,0, 1,32'h1, 0,1, 0,0);
    add(0,1,0,0,0,0, 1,0, 0,1, 0,0);
    // Flush while RX is not full: the same-edge RX push must be dropped.
    add(0,0,0,0,1,32'hC001, 1,0, 0,1, 0,0);
    add(1,3,32'h3,0,1,32'hC002, 1,32'h1, 0,1, 0,0);
    add(0,2,0,0,0,0, 1,32'h0A, 0,1, 0,0);
    add(0,1,0,0,0,0, 1,0, 0,1, 0,0);

    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < vq.size(); i++) apply(vq[i], i);

    // Address outside the window: not selected, reads 0.
    WE = 1'b0; A = 32'h0000_2008; #2;
    check("outside_sel", {31'd0, sel}, 32'd0);
    check("outside_rd", RD, 32'd0);
    @(posedge clk); #1;

    // Asynchronous reset mid-stream.
    WE = 1'b1; A = 32'h0000_1000; WD = 32'h55; tx_ready = 1'b0;
    @(posedge clk); #1;
    WE = 1'b0; A = 32'h0000_1008; #1;
    check("pre_reset_tx_valid", {31'd0, tx_valid}, 32'd1);
    #1 reset = 1'b0;
    #1;
    check("async_tx_valid", {31'd0, tx_valid}, 32'd0);
    check("async_rx_ready", {31'd0, rx_ready}, 32'd1);
    check("async_status", RD, 32'h0000_000A);
    #1 reset = 1'b1;
    @(posedge clk); #1;
    A = 32'h0000_100C; #1;
    check("post_reset_ctrl", RD, 32'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
